// File: rtl/ram_line_taps_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : ram_line_taps_pkg
//  Description : Shared constants and helpers for the multi-tap RAM line
//                buffer (delay-length clamping).
//  Revision    : 1.0  initial release
// ============================================================================
package ram_line_taps_pkg;

    // Shortest usable per-stage delay; a one-entry circular RAM cannot
    // provide read-before-write spacing across a wrap.
    localparam int c_MIN_DELAY = 2;

    // Clamp a requested stage delay into [c_MIN_DELAY, max].
    function automatic logic [31:0] clamp_delay(input logic [31:0] len,
                                                input logic [31:0] max);
        if (len < 32'(c_MIN_DELAY)) begin
            return 32'(c_MIN_DELAY);
        end else if (len > max) begin
            return max;
        end else begin
            return len;
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_delay_stage.sv
`default_nettype none
// ============================================================================
//  Module      : line_delay_stage
//  Description : One circular-RAM delay stage. Read-before-write at a shared
//                address; exposes the raw read word (feeds the next stage in
//                the same strobe) and a registered copy of it.
//  Revision    : 1.0  initial release
// ============================================================================
module line_delay_stage #(
    parameter int MAX_DELAY  = 1024,
    parameter int DATA_WIDTH = 24,
    parameter int ADDR_W     = $clog2(MAX_DELAY)
) (
    input  logic                  clock,
    input  logic                  clken_i,
    input  logic [ADDR_W-1:0]     addr_i,
    input  logic [DATA_WIDTH-1:0] din_i,
    output logic [DATA_WIDTH-1:0] rd_o,
    output logic [DATA_WIDTH-1:0] dout_o
);

    logic [DATA_WIDTH-1:0] mem_q [MAX_DELAY];
    logic [DATA_WIDTH-1:0] dout_q;

    // Old word at the address, before this strobe overwrites it.
    assign rd_o   = mem_q[addr_i];
    assign dout_o = dout_q;

    // Strobed write with read-before-write capture; contents are never cleared.
    always_ff @(posedge clock) begin
        if (clken_i) begin
            mem_q[addr_i] <= din_i;
            dout_q        <= mem_q[addr_i];
        end
    end

endmodule
`default_nettype wire

// File: rtl/ram_line_taps.sv
`default_nettype none
// ============================================================================
//  Module      : ram_line_taps
//  Description : Multi-tap RAM line buffer. NUM_TAPS cascaded circular-RAM
//                stages of runtime length D; tap k delays the input by
//                (k+1)*D accepted samples, with per-tap valid masking.
//  Revision    : 1.0  initial release
// ============================================================================
module ram_line_taps
    import ram_line_taps_pkg::*;
#(
    parameter int MAX_DELAY  = 1024,
    parameter int DATA_WIDTH = 24,
    parameter int NUM_TAPS   = 3
) (
    input  logic                           clock,
    input  logic                           rst_n,
    input  logic                           clken,
    input  logic                           flush,
    input  logic [$clog2(MAX_DELAY+1)-1:0] delay_len,
    input  logic [DATA_WIDTH-1:0]          shiftin,
    output logic [NUM_TAPS*DATA_WIDTH-1:0] taps_out,
    output logic [NUM_TAPS-1:0]            tap_valid
);

    localparam int ADDR_W = $clog2(MAX_DELAY);
    localparam int LEN_W  = $clog2(MAX_DELAY + 1);
    localparam int FILL_W = $clog2(NUM_TAPS * MAX_DELAY + 1);

    logic [LEN_W-1:0]               dlen_q, dlen_d;
    logic [ADDR_W-1:0]              addr_q, addr_d;
    logic [FILL_W-1:0]              fill_q, fill_d;
    logic [NUM_TAPS-1:0]            vpipe_q, vpipe_d;
    logic [NUM_TAPS-1:0]            tvalid_q, tvalid_d;
    logic [NUM_TAPS*DATA_WIDTH-1:0] taps_q, taps_d;

    logic                           w_restart;
    logic                           w_accept;
    logic [FILL_W-1:0]              w_fill_max;
    logic [NUM_TAPS-1:0]            w_ready;
    logic [DATA_WIDTH-1:0]          w_din  [NUM_TAPS];
    logic [DATA_WIDTH-1:0]          w_rd   [NUM_TAPS];
    logic [DATA_WIDTH-1:0]          w_dout [NUM_TAPS];

    // Reset and flush share one restart path; a strobe during restart is dropped.
    assign w_restart  = !rst_n || flush;
    assign w_accept   = clken && !w_restart;
    assign w_fill_max = FILL_W'(NUM_TAPS) * FILL_W'(dlen_q);

    generate
        for (genvar k = 0; k < NUM_TAPS; k++) begin : g_stage
            if (k == 0) begin : g_head
                assign w_din[k] = shiftin;
            end else begin : g_chain
                assign w_din[k] = w_rd[k-1];
            end

            // The word read now is real once (k+1)*D samples preceded it.
            assign w_ready[k] = (fill_q >= FILL_W'(k + 1) * FILL_W'(dlen_q));

            line_delay_stage #(
                .MAX_DELAY  (MAX_DELAY),
                .DATA_WIDTH (DATA_WIDTH),
                .ADDR_W     (ADDR_W)
            ) u_stage (
                .clock   (clock),
                .clken_i (w_accept),
                .addr_i  (addr_q),
                .din_i   (w_din[k]),
                .rd_o    (w_rd[k]),
                .dout_o  (w_dout[k])
            );
        end
    endgenerate

    // Next-state: restart loading, strobed address/fill advance, masked outputs.
    always_comb begin
        dlen_d   = dlen_q;
        addr_d   = addr_q;
        fill_d   = fill_q;
        vpipe_d  = vpipe_q;
        tvalid_d = tvalid_q;
        taps_d   = taps_q;
        if (w_restart) begin
            dlen_d   = LEN_W'(clamp_delay(32'(delay_len), 32'(MAX_DELAY)));
            addr_d   = '0;
            fill_d   = '0;
            vpipe_d  = '0;
            tvalid_d = '0;
            taps_d   = '0;
        end else begin
            if (clken) begin
                addr_d  = (LEN_W'(addr_q) == dlen_q - LEN_W'(1)) ? '0
                                                                  : addr_q + ADDR_W'(1);
                fill_d  = (fill_q >= w_fill_max) ? fill_q : fill_q + FILL_W'(1);
                vpipe_d = w_ready;
            end
            // Output stage runs every clock; it holds naturally between strobes.
            tvalid_d = vpipe_q;
            for (int k = 0; k < NUM_TAPS; k++) begin
                taps_d[k*DATA_WIDTH +: DATA_WIDTH] = vpipe_q[k] ? w_dout[k] : '0;
            end
        end
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        dlen_q   <= dlen_d;
        addr_q   <= addr_d;
        fill_q   <= fill_d;
        vpipe_q  <= vpipe_d;
        tvalid_q <= tvalid_d;
        taps_q   <= taps_d;
    end

    assign taps_out  = taps_q;
    assign tap_valid = tvalid_q;

endmodule
`default_nettype wire

// File: tb/tb_ram_line_taps.sv
`default_nettype none
// ============================================================================
//  Module      : tb_ram_line_taps
//  Description : Directed self-checking bench for ram_line_taps
//                (DW=24, NUM_TAPS=3, MAX_DELAY=16).
//  Revision    : 1.0  initial release
// ============================================================================
module tb_ram_line_taps;

    localparam int DW = 24;
    localparam int NT = 3;
    localparam int MD = 16;
    localparam int LW = $clog2(MD + 1);

    logic            clock     = 1'b0;
    logic            rst_n     = 1'b0;
    logic            clken     = 1'b0;
    logic            flush     = 1'b0;
    logic [LW-1:0]   delay_len = '0;
    logic [DW-1:0]   shiftin   = '0;
    logic [NT*DW-1:0] taps_out;
    logic [NT-1:0]   tap_valid;

    int n_checks = 0;
    int n_errors = 0;

    // Expected-value state: effective delay, index of last accepted sample,
    // and the value offset of the current stream (sample n carries base+n+1).
    int d_m  = 2;
    int last = -1;
    int base = 0;

    always #5 clock = ~clock;

    ram_line_taps #(
        .MAX_DELAY  (MD),
        .DATA_WIDTH (DW),
        .NUM_TAPS   (NT)
    ) dut (
        .clock     (clock),
        .rst_n     (rst_n),
        .clken     (clken),
        .flush     (flush),
        .delay_len (delay_len),
        .shiftin   (shiftin),
        .taps_out  (taps_out),
        .tap_valid (tap_valid)
    );

    task automatic check(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int clamp_m(input int len);
        if (len < 2)  return 2;
        if (len > MD) return MD;
        return len;
    endfunction

    // Apply one clock of stimulus, then check taps and valid against the
    // stream index that the output registers should be showing.
    task automatic cycle(input logic ce, input logic fl, input logic rn,
                         input int len, input string tag);
        int          m_out;
        logic [71:0] et;
        logic [NT-1:0] ev;
        logic        restart;
        restart   = !rn || fl;
        clken     = ce;
        flush     = fl;
        rst_n     = rn;
        delay_len = LW'(len);
        shiftin   = restart ? 24'hABCDEF : DW'(base + last + 2);
        @(posedge clock);
        #1;
        et    = '0;
        ev    = '0;
        m_out = -1;
        if (restart) begin
            d_m  = clamp_m(len);
            last = -1;
        end else begin
            m_out = last;
            if (ce) last++;
            for (int k = 0; k < NT; k++) begin
                if (m_out >= (k + 1) * d_m) begin
                    et[k*DW +: DW] = DW'(base + m_out - (k + 1) * d_m + 1);
                    ev[k]          = 1'b1;
                end
            end
        end
        check({tag, " taps"},  72'(taps_out),  et);
        check({tag, " valid"}, 72'(tap_valid), 72'(ev));
    endtask

    initial begin
        // 1: D=4, continuous strobe; taps become valid at E_4+1, E_8+1, E_12+1.
        base = 0;
        cycle(1'b1, 1'b0, 1'b0, 4, "t1 reset");
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b1, 4, "t1 stream");

        // 2: same length with the strobe toggling; outputs hold on idle cycles.
        base = 100;
        cycle(1'b0, 1'b0, 1'b0, 4, "t2 reset");
        for (int i = 0; i < 40; i++) cycle(((i % 2) == 0), 1'b0, 1'b1, 4, "t2 toggle");

        // 3: out-of-range lengths clamp to 2 and to MAX_DELAY.
        base = 200;
        cycle(1'b0, 1'b0, 1'b0, 0, "t3 reset lo");
        for (int i = 0; i < 10; i++) cycle(1'b1, 1'b0, 1'b1, 0, "t3 D=2");
        base = 300;
        cycle(1'b0, 1'b0, 1'b0, 31, "t3 reset hi");
        for (int i = 0; i < 52; i++) cycle(1'b1, 1'b0, 1'b1, 31, "t3 D=16");

        // 4: fill at D=4, flush with a new length and a simultaneous strobe.
        base = 'h1000;
        cycle(1'b0, 1'b0, 1'b0, 4, "t4 reset");
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b1, 4, "t4 fill");
        cycle(1'b1, 1'b1, 1'b1, 6, "t4 flush");
        base = 'h2000;
        for (int i = 0; i < 22; i++) cycle(1'b1, 1'b0, 1'b1, 6, "t4 post");

        // 5: delay_len changes without flush are ignored.
        base = 'h3000;
        cycle(1'b0, 1'b0, 1'b0, 4, "t5 reset");
        for (int i = 0; i < 8; i++)  cycle(1'b1, 1'b0, 1'b1, 4, "t5 pre");
        for (int i = 0; i < 16; i++) cycle(1'b1, 1'b0, 1'b1, 9, "t5 chg");

        // 6: one-cycle reset mid-stream; stale RAM contents stay masked.
        cycle(1'b1, 1'b0, 1'b0, 5, "t6 reset");
        base = 'h4000;
        for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, 1'b1, 5, "t6 stream");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
